// File: rtl/vga_timing_receiver_if.sv
// VGA pixel bus as driven by the controller: syncs, data enable and 8-bit colour.
// All signals are sampled on the receiver's pixel clock.
interface vga_timing_receiver_if;
  logic       hs;
  logic       vs;
  logic       video_on;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (output hs, vs, video_on, red, green, blue);
  modport slave  (input  hs, vs, video_on, red, green, blue);
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA receive front end: recovers active-pixel coordinates, measures line/frame
// timing, declares lock after stable frames and captures the colour of one probe pixel.
module vga_timing_receiver #(
  parameter int unsigned CW          = 12,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_timing_receiver_if.slave vga_i,
  input  logic [CW-1:0]        probe_x_i,
  input  logic [CW-1:0]        probe_y_i,
  output logic                 pix_valid_o,
  output logic [CW-1:0]        pix_x_o,
  output logic [CW-1:0]        pix_y_o,
  output logic [23:0]          pix_rgb_o,
  output logic                 frame_start_o,
  output logic [CW-1:0]        h_total_o,
  output logic [CW-1:0]        h_active_o,
  output logic [CW-1:0]        v_total_o,
  output logic [CW-1:0]        v_active_o,
  output logic                 locked_o,
  output logic [23:0]          probe_rgb_o,
  output logic                 probe_hit_o
);

  localparam int unsigned MW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] TmoVal = CW'(TIMEOUT);
  localparam logic [MW-1:0] LockCnt = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {StWait, StMeasure, StVerify, StLock} state_e;

  // Stage 1 input registers and their previous values for edge detection
  logic          hs_q, vs_q, von_q, hs_prev_q, vs_prev_q;
  logic [23:0]   rgb_q;

  logic [CW-1:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d;
  logic [CW-1:0] line_cnt_q, line_cnt_d, y_cnt_q, y_cnt_d;
  logic          line_act_q, line_act_d;
  logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;

  // Stage 2 output registers
  logic          pix_valid_q, frame_start_q, probe_hit_q;
  logic [CW-1:0] pix_x_q, pix_y_q;
  logic [23:0]   pix_rgb_q, probe_rgb_q;

  state_e           state_q;
  logic [4*CW-1:0]  ref_q, meas_d;
  logic [MW-1:0]    match_q;
  logic             locked_q;

  logic hs_fall, vs_fall, line_act, timeout, probe_match;

  always_comb begin
    hs_fall    = hs_prev_q & ~hs_q;
    vs_fall    = vs_prev_q & ~vs_q;
    line_act   = line_act_q | von_q;

    h_cnt_d    = hs_fall ? '0 : ((h_cnt_q == CntMax) ? h_cnt_q : h_cnt_q + CW'(1));
    a_cnt_d    = hs_fall ? '0 :
                 ((von_q && (a_cnt_q != CntMax)) ? a_cnt_q + CW'(1) : a_cnt_q);
    line_act_d = hs_fall ? 1'b0 : line_act;
    line_cnt_d = vs_fall ? '0 : line_cnt_q + CW'(hs_fall);
    y_cnt_d    = vs_fall ? '0 : y_cnt_q + CW'(hs_fall & line_act);

    h_total_d  = hs_fall ? h_cnt_q + CW'(1) : h_total_q;
    h_active_d = hs_fall ? a_cnt_q : h_active_q;
    // A line ending on the same cycle as VS belongs to the frame that is closing
    v_total_d  = vs_fall ? line_cnt_q + CW'(hs_fall) : v_total_q;
    v_active_d = vs_fall ? y_cnt_q + CW'(hs_fall & line_act) : v_active_q;

    meas_d      = {h_total_d, h_active_d, v_total_d, v_active_d};
    // Fire once, on the edge where h_cnt arrives at the limit
    timeout     = (h_cnt_d == TmoVal) && (h_cnt_q != TmoVal);
    probe_match = pix_valid_q && (pix_x_q == probe_x_i) && (pix_y_q == probe_y_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      von_q         <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      rgb_q         <= '0;
      h_cnt_q       <= '0;
      a_cnt_q       <= '0;
      line_cnt_q    <= '0;
      y_cnt_q       <= '0;
      line_act_q    <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      probe_rgb_q   <= '0;
      probe_hit_q   <= 1'b0;
    end else begin
      hs_q          <= vga_i.hs;
      vs_q          <= vga_i.vs;
      von_q         <= vga_i.video_on;
      rgb_q         <= {vga_i.red, vga_i.green, vga_i.blue};
      hs_prev_q     <= hs_q;
      vs_prev_q     <= vs_q;
      h_cnt_q       <= h_cnt_d;
      a_cnt_q       <= a_cnt_d;
      line_cnt_q    <= line_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_act_q    <= line_act_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      pix_valid_q   <= von_q;
      pix_x_q       <= a_cnt_q;
      pix_y_q       <= y_cnt_q;
      pix_rgb_q     <= rgb_q;
      frame_start_q <= vs_fall;
      probe_hit_q   <= probe_match;
      if (probe_match) probe_rgb_q <= pix_rgb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StWait;
      ref_q    <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
    end else if (timeout) begin
      state_q  <= StWait;
      match_q  <= '0;
      locked_q <= 1'b0;
    end else if (vs_fall) begin
      unique case (state_q)
        StWait: state_q <= StMeasure;
        StMeasure: begin
          ref_q   <= meas_d;
          match_q <= MW'(1);
          state_q <= StVerify;
        end
        StVerify: begin
          if (meas_d == ref_q) begin
            match_q <= match_q + MW'(1);
            if (match_q + MW'(1) >= LockCnt) begin
              state_q  <= StLock;
              locked_q <= 1'b1;
            end
          end else begin
            ref_q   <= meas_d;
            match_q <= MW'(1);
          end
        end
        StLock: begin
          if (meas_d != ref_q) begin
            locked_q <= 1'b0;
            ref_q    <= meas_d;
            match_q  <= MW'(1);
            state_q  <= StVerify;
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign pix_valid_o   = pix_valid_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign pix_rgb_o     = pix_rgb_q;
  assign frame_start_o = frame_start_q;
  assign h_total_o     = h_total_q;
  assign h_active_o    = h_active_q;
  assign v_total_o     = v_total_q;
  assign v_active_o    = v_active_q;
  assign locked_o      = locked_q;
  assign probe_rgb_o   = probe_rgb_q;
  assign probe_hit_o   = probe_hit_q;

endmodule
